// File: rtl/npc_pkg.sv
// Shared NPC core constants: RV funct3 size encodings, major opcodes and LSU states.
package npc_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef logic [1:0] lsu_state_t;
  localparam lsu_state_t LSU_IDLE = 2'd0;
  localparam lsu_state_t LSU_REQ  = 2'd1;
  localparam lsu_state_t LSU_WAIT = 2'd2;
  localparam lsu_state_t LSU_RESP = 2'd3;

endpackage

// File: rtl/npc_lsu_align.sv
// Combinational LSU datapath: legality, lane mask and store shift on the request side;
// load lane extraction and sign/zero extension on the response side.
module npc_lsu_align
  import npc_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int CHECK_ALIGN = 1,
  localparam int MASK_W     = XLEN / 8,
  localparam int OFF_W      = $clog2(MASK_W)
) (
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   wdata,
  output logic              legal,
  output logic [OFF_W-1:0]  off,
  output logic [ADDR_W-1:0] aligned_addr,
  output logic [MASK_W-1:0] wmask,
  output logic [XLEN-1:0]   wdata_sh,
  input  logic [2:0]        rsp_funct3,
  input  logic [OFF_W-1:0]  rsp_off,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN-1:0]   rdata_ext
);

  logic [OFF_W-1:0]        raw_off;
  logic [OFF_W-1:0]        lo_mask;
  logic [7:0]              size_mask;
  logic [6:0]              ext_sa;
  logic [XLEN-1:0]         rd_sh;
  logic [XLEN-1:0]         rd_top;
  logic signed [XLEN-1:0]  rd_sext;

  always_comb begin
    raw_off  = addr[OFF_W-1:0];
    lo_mask  = OFF_W'((4'd1 << funct3[1:0]) - 4'd1);
    // With alignment checks off, the sub-size offset bits are simply dropped.
    off      = (CHECK_ALIGN != 0) ? raw_off : (raw_off & ~lo_mask);
    legal    = (funct3 != 3'b111)
             && !((XLEN == 32) && ((funct3 == F3_D) || (funct3 == F3_WU)))
             && !(we && funct3[2])
             && !((CHECK_ALIGN != 0) && ((raw_off & lo_mask) != '0));
    aligned_addr = addr & ~ADDR_W'(MASK_W - 1);

    case (funct3[1:0])
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
    wmask    = we ? (MASK_W'(size_mask) << off) : '0;
    wdata_sh = wdata << {off, 3'b000};

    // Push the selected field to the top, then shift back down logically or arithmetically.
    rd_sh     = rdata >> {rsp_off, 3'b000};
    ext_sa    = 7'(XLEN) - (7'd8 << rsp_funct3[1:0]);
    rd_top    = rd_sh << ext_sa;
    rd_sext   = $signed(rd_top) >>> ext_sa;
    rdata_ext = rsp_funct3[2] ? (rd_top >> ext_sa) : rd_sext;
  end

endmodule

// File: rtl/npc_lsu.sv
// Multi-cycle RV load/store unit: one request at a time, 2-cycle minimum accept-to-result, 1 cycle on error.
// Backpressure: req_ready only in IDLE; bus request held until mem_req_ready; result held until resp_ready.
module npc_lsu
  import npc_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int CHECK_ALIGN = 1,
  localparam int MASK_W     = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int OFF_W = $clog2(MASK_W);

  lsu_state_t        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic              mem_req_valid_q, mem_req_valid_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [MASK_W-1:0] mem_wmask_q, mem_wmask_d;
  logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic              a_legal;
  logic [OFF_W-1:0]  a_off;
  logic [ADDR_W-1:0] a_addr;
  logic [MASK_W-1:0] a_wmask;
  logic [XLEN-1:0]   a_wdata;
  logic [XLEN-1:0]   a_rdata_ext;

  npc_lsu_align #(
    .XLEN        (XLEN),
    .ADDR_W      (ADDR_W),
    .CHECK_ALIGN (CHECK_ALIGN)
  ) u_align (
    .we           (req_we),
    .funct3       (req_funct3),
    .addr         (req_addr),
    .wdata        (req_wdata),
    .legal        (a_legal),
    .off          (a_off),
    .aligned_addr (a_addr),
    .wmask        (a_wmask),
    .wdata_sh     (a_wdata),
    .rsp_funct3   (f3_q),
    .rsp_off      (off_q),
    .rdata        (mem_rdata),
    .rdata_ext    (a_rdata_ext)
  );

  always_comb begin
    state_d         = state_q;
    we_d            = we_q;
    f3_d            = f3_q;
    off_d           = off_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    mem_wmask_d     = mem_wmask_q;
    resp_rdata_d    = resp_rdata_q;
    resp_err_d      = resp_err_q;

    case (state_q)
      LSU_IDLE: begin
        if (req_valid) begin
          we_d         = req_we;
          f3_d         = req_funct3;
          off_d        = a_off;
          resp_rdata_d = '0;
          resp_err_d   = !a_legal;
          if (a_legal) begin
            state_d         = LSU_REQ;
            mem_req_valid_d = 1'b1;
            mem_we_d        = req_we;
            mem_addr_d      = a_addr;
            mem_wdata_d     = a_wdata;
            mem_wmask_d     = a_wmask;
          end else begin
            state_d = LSU_RESP;
          end
        end
      end
      LSU_REQ: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          // A response in the handshake cycle bypasses WAIT entirely.
          if (mem_rsp_valid) begin
            state_d      = LSU_RESP;
            resp_rdata_d = we_q ? '0 : a_rdata_ext;
          end else begin
            state_d = LSU_WAIT;
          end
        end
      end
      LSU_WAIT: begin
        if (mem_rsp_valid) begin
          state_d      = LSU_RESP;
          resp_rdata_d = we_q ? '0 : a_rdata_ext;
        end
      end
      LSU_RESP: begin
        if (resp_ready) state_d = LSU_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= LSU_IDLE;
      we_q            <= 1'b0;
      f3_q            <= 3'b000;
      off_q           <= '0;
      mem_req_valid_q <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_wmask_q     <= '0;
      resp_rdata_q    <= '0;
      resp_err_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      we_q            <= we_d;
      f3_q            <= f3_d;
      off_q           <= off_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_wmask_q     <= mem_wmask_d;
      resp_rdata_q    <= resp_rdata_d;
      resp_err_q      <= resp_err_d;
    end
  end

  assign req_ready     = (state_q == LSU_IDLE);
  assign resp_valid    = (state_q == LSU_RESP);
  assign resp_rdata    = resp_rdata_q;
  assign resp_err      = resp_err_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wmask     = mem_wmask_q;

endmodule
